// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access path.
// Contents:
//   OPC_LOAD / OPC_STORE   control-unit opcode constants
//   F3_*                   RISC-V load/store FUNCT3 size/sign codes
//   state_e                access sequencer states
//   f3_bytes()             access width in bytes for a FUNCT3 code
//   lane_mask()            64-bit mask covering the bytes an access touches
package mem_access_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_D  = 3'd3;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    localparam logic [2:0] F3_WU = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        RESP   = 3'd4
    } state_e;

    // Unsigned variants share the width of their signed counterparts.
    function automatic logic [3:0] f3_bytes(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return 4'd1;
            F3_H, F3_HU: return 4'd2;
            F3_W, F3_WU: return 4'd4;
            default:     return 4'd8;
        endcase
    endfunction

    function automatic logic [63:0] lane_mask(input logic [2:0] f3, input logic [2:0] off);
        logic [7:0]  be;
        logic [63:0] m;
        be = 8'((9'h001 << f3_bytes(f3)) - 9'h001) << off;
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between the control unit, the access sequencer and the data memory.
// Request side : REQ, WE, FUNCT3, ADDR, WDATA in; BUSY, DONE, ERR, RDATA out.
// Memory side  : MEM_RD, MEM_WR, MEM_ADDR, MEM_WDATA out; MEM_RDATA, MEM_READY in.
//
// Handshake: a request is taken when REQ is high while the sequencer is idle
// (BUSY low). Toward memory, MEM_RD or MEM_WR acts as valid and MEM_READY as
// ready: a strobe and its address/data stay stable until a cycle in which
// MEM_READY is high, and that cycle completes the transfer. DONE pulses for one
// cycle per accepted request, with ERR qualifying it.
//
// Modports: slave = the sequencer, master = its environment (control unit + memory).
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 64
) ();
    logic              REQ;
    logic              WE;
    logic [2:0]        FUNCT3;
    logic [ADDR_W-1:0] ADDR;
    logic [63:0]       WDATA;
    logic              BUSY;
    logic              DONE;
    logic              ERR;
    logic [63:0]       RDATA;
    logic              MEM_RD;
    logic              MEM_WR;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [63:0]       MEM_WDATA;
    logic [63:0]       MEM_RDATA;
    logic              MEM_READY;

    modport slave (
        input  REQ, WE, FUNCT3, ADDR, WDATA, MEM_RDATA, MEM_READY,
        output BUSY, DONE, ERR, RDATA, MEM_RD, MEM_WR, MEM_ADDR, MEM_WDATA
    );

    modport master (
        output REQ, WE, FUNCT3, ADDR, WDATA, MEM_RDATA, MEM_READY,
        input  BUSY, DONE, ERR, RDATA, MEM_RD, MEM_WR, MEM_ADDR, MEM_WDATA
    );
endinterface

// File: rtl/mem_access_ctrl_load_extend.sv
// Load data alignment: shifts a 64-bit doubleword right by the byte offset,
// keeps the field selected by FUNCT3 and sign- or zero-extends it to 64 bits.
// Ports:
//   dword_i   64-bit doubleword as read from memory
//   offset_i  byte offset of the access inside the doubleword
//   funct3_i  load size/sign code
//   data_o    extended result
module load_extend
    import mem_access_ctrl_pkg::*;
(
    input  logic [63:0] dword_i,
    input  logic [2:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [63:0] data_o
);
    logic [63:0] shifted;

    assign shifted = dword_i >> {offset_i, 3'b000};

    always_comb begin
        case (funct3_i)
            F3_B:    data_o = {{56{shifted[7]}},  shifted[7:0]};
            F3_H:    data_o = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    data_o = {{32{shifted[31]}}, shifted[31:0]};
            F3_BU:   data_o = {56'd0, shifted[7:0]};
            F3_HU:   data_o = {48'd0, shifted[15:0]};
            F3_WU:   data_o = {32'd0, shifted[31:0]};
            default: data_o = shifted;
        endcase
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer. Takes one load/store request from the control
// unit, checks size and alignment, runs the memory read / write (with a
// read-modify-write for sub-doubleword stores), extends load data and answers
// with a one-cycle DONE (+ERR on illegal size, misalignment or timeout).
// Ports:
//   CLK          rising-edge clock
//   RESET        asynchronous active-high reset
//   bus          request + memory signals (slave side)
//   dbg_state_o  current sequencer state
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                     CLK,
    input  logic                     RESET,
    mem_access_ctrl_if.slave         bus,
    output state_e                   dbg_state_o
);
    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [63:0]       rdata_q, rdata_d;

    logic [63:0]       load_val;
    logic [63:0]       merge_mask;
    logic [63:0]       merged;
    logic [2:0]        align_mask;
    logic              req_bad;
    logic              wait_expired;

    load_extend u_load_extend (
        .dword_i  (bus.MEM_RDATA),
        .offset_i (addr_q[2:0]),
        .funct3_i (f3_q),
        .data_o   (load_val)
    );

    // Sub-doubleword store: overlay the positioned store bytes on the read word.
    assign merge_mask = lane_mask(f3_q, addr_q[2:0]);
    assign merged     = (bus.MEM_RDATA & ~merge_mask)
                      | ((wdata_q << {addr_q[2:0], 3'b000}) & merge_mask);

    // Width-1 of the requested access doubles as its alignment mask (8 -> 3'b111).
    assign align_mask = 3'(f3_bytes(bus.FUNCT3) - 4'd1);
    assign req_bad    = (bus.WE ? bus.FUNCT3[2] : (bus.FUNCT3 == 3'd7))
                      | (|(bus.ADDR[2:0] & align_mask));

    // The current cycle is the WAIT_LIMIT-th without MEM_READY.
    assign wait_expired = (cnt_q == CNT_W'(WAIT_LIMIT - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.REQ) begin
                    f3_d    = bus.FUNCT3;
                    addr_d  = bus.ADDR;
                    wdata_d = bus.WDATA;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    if (req_bad) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (!bus.WE) begin
                        state_d = RD;
                    end else if (bus.FUNCT3 == F3_D) begin
                        state_d = WR;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            RD, RMW_RD, WR: begin
                if (bus.MEM_READY) begin
                    if (state_q == RD) begin
                        rdata_d = load_val;
                        state_d = RESP;
                    end else if (state_q == RMW_RD) begin
                        wdata_d = merged;
                        cnt_d   = '0;
                        state_d = WR;
                    end else begin
                        state_d = RESP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (wait_expired) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.BUSY      = (state_q != IDLE);
        bus.DONE      = (state_q == RESP);
        bus.ERR       = (state_q == RESP) && err_q;
        bus.RDATA     = rdata_q;
        bus.MEM_RD    = (state_q == RD) || (state_q == RMW_RD);
        bus.MEM_WR    = (state_q == WR);
        bus.MEM_ADDR  = (state_q == IDLE) ? '0 : {addr_q[ADDR_W-1:3], 3'b000};
        bus.MEM_WDATA = (state_q == WR) ? wdata_q : 64'd0;
        dbg_state_o   = state_q;
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: inputs change and outputs are observed on
// the falling clock edge; a one-word memory model answers the strobes.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic   clk;
    logic   rst;
    state_e dbg_state;

    mem_access_ctrl_if #(.ADDR_W(64)) bus ();

    mem_access_ctrl #(.ADDR_W(64), .WAIT_LIMIT(15)) dut (
        .CLK         (clk),
        .RESET       (rst),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] mem_word;
    assign bus.MEM_RDATA = mem_word;

    int n_total = 0;
    int n_pass  = 0;

    // Results of the last run_req call.
    int          lat;
    int          rd_cyc;
    int          wr_cyc;
    logic        got_done;
    logic        err_seen;
    logic        addr_ok;
    logic        both_seen;
    logic        busy_after;
    logic [63:0] last_wdata;
    logic [63:0] last_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one request at the current falling edge and follow it to DONE.
    // The memory raises MEM_READY after 'delay' cycles of each strobe phase
    // (delay < 0: never). Ends on the falling edge after DONE.
    task automatic run_req(input logic we, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] wd,
                           input int delay);
        int phase;
        int prev;
        int run;
        bus.REQ = 1'b1; bus.WE = we; bus.FUNCT3 = f3; bus.ADDR = addr; bus.WDATA = wd;
        bus.MEM_READY = 1'b0;
        lat = 0; rd_cyc = 0; wr_cyc = 0; got_done = 1'b0; err_seen = 1'b0;
        addr_ok = 1'b1; both_seen = 1'b0; last_wdata = '0; last_addr = '0;
        prev = 0; run = 0;
        for (int c = 1; c <= 40 && !got_done; c++) begin
            @(negedge clk);
            bus.REQ = 1'b0;
            if (bus.MEM_RD && bus.MEM_WR) both_seen = 1'b1;
            phase = bus.MEM_RD ? 1 : (bus.MEM_WR ? 2 : 0);
            if (phase == 0) begin
                run = 0;
                bus.MEM_READY = 1'b0;
            end else begin
                last_addr = bus.MEM_ADDR;
                if (bus.MEM_ADDR !== {addr[63:3], 3'b000}) addr_ok = 1'b0;
                if (phase == 1) rd_cyc++;
                if (phase == 2) begin
                    wr_cyc++;
                    last_wdata = bus.MEM_WDATA;
                end
                if (phase != prev) run = 0;
                run++;
                bus.MEM_READY = (delay >= 0) && (run > delay);
                if (phase == 2 && bus.MEM_READY) mem_word = bus.MEM_WDATA;
            end
            prev = phase;
            if (bus.DONE) begin
                got_done = 1'b1;
                lat      = c;
                err_seen = bus.ERR;
            end
        end
        chk("done_seen", 64'(got_done), 64'd1);
        @(negedge clk);
        bus.MEM_READY = 1'b0;
        busy_after = bus.BUSY;
    endtask

    initial begin
        int done_cnt;
        rst = 1'b1;
        bus.REQ = 1'b0; bus.WE = 1'b0; bus.FUNCT3 = '0; bus.ADDR = '0; bus.WDATA = '0;
        bus.MEM_READY = 1'b0;
        mem_word = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy",  64'(bus.BUSY),   64'd0);
        chk("rst_done",  64'(bus.DONE),   64'd0);
        chk("rst_err",   64'(bus.ERR),    64'd0);
        chk("rst_rdata", bus.RDATA,       64'd0);
        chk("rst_rd",    64'(bus.MEM_RD), 64'd0);
        chk("rst_wr",    64'(bus.MEM_WR), 64'd0);
        chk("rst_maddr", bus.MEM_ADDR,    64'd0);
        chk("rst_state", 64'(dbg_state),  64'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        // lb at 0x13, byte 3 = 0x80
        mem_word = 64'h00000000_80FF0000;
        run_req(1'b0, F3_B, 64'h13, 64'd0, 0);
        chk("lb_lat",   64'(lat),    64'd2);
        chk("lb_err",   64'(err_seen), 64'd0);
        chk("lb_rdata", bus.RDATA,   64'hFFFFFFFF_FFFFFF80);
        chk("lb_maddr", last_addr,   64'h10);
        chk("lb_rdcyc", 64'(rd_cyc), 64'd1);
        chk("lb_wrcyc", 64'(wr_cyc), 64'd0);
        chk("lb_idle",  64'(busy_after), 64'd0);

        // lhu / lh at 0x0E
        mem_word = 64'hBEEF0000_00000000;
        run_req(1'b0, F3_HU, 64'h0E, 64'd0, 0);
        chk("lhu_rdata", bus.RDATA, 64'h00000000_0000BEEF);
        run_req(1'b0, F3_H, 64'h0E, 64'd0, 0);
        chk("lh_rdata",  bus.RDATA, 64'hFFFFFFFF_FFFFBEEF);
        chk("lh_lat",    64'(lat),  64'd2);

        // sb 0xAA at 0x21 (read-modify-write)
        mem_word = 64'h11223344_55667788;
        run_req(1'b1, F3_B, 64'h21, 64'h00000000_000000AA, 0);
        chk("sb_lat",    64'(lat),    64'd3);
        chk("sb_err",    64'(err_seen), 64'd0);
        chk("sb_rdcyc",  64'(rd_cyc), 64'd1);
        chk("sb_wrcyc",  64'(wr_cyc), 64'd1);
        chk("sb_wdata",  last_wdata,  64'h11223344_5566AA88);
        chk("sb_maddr",  64'(addr_ok), 64'd1);
        chk("sb_excl",   64'(both_seen), 64'd0);
        chk("sb_rdhold", bus.RDATA,   64'hFFFFFFFF_FFFFBEEF);

        // sh at 0x36: bytes 6..7 replaced
        mem_word = 64'h11223344_55667788;
        run_req(1'b1, F3_H, 64'h36, 64'h00000000_0000CDEF, 0);
        chk("sh_wdata", last_wdata, 64'hCDEF3344_55667788);

        // Misaligned sw and illegal load code
        run_req(1'b1, F3_W, 64'h06, 64'h12345678, 0);
        chk("sw_mis_lat", 64'(lat),    64'd1);
        chk("sw_mis_err", 64'(err_seen), 64'd1);
        chk("sw_mis_str", 64'(rd_cyc + wr_cyc), 64'd0);
        run_req(1'b0, 3'd7, 64'h08, 64'd0, 0);
        chk("ld7_lat", 64'(lat),    64'd1);
        chk("ld7_err", 64'(err_seen), 64'd1);
        chk("ld7_str", 64'(rd_cyc + wr_cyc), 64'd0);
        // store code 4 is illegal even when aligned
        run_req(1'b1, 3'd4, 64'h08, 64'd0, 0);
        chk("st4_err", 64'(err_seen), 64'd1);

        // ld at 0x40, READY after 4 wait cycles
        mem_word = 64'h01234567_89ABCDEF;
        run_req(1'b0, F3_D, 64'h40, 64'd0, 4);
        chk("ldw_rdcyc", 64'(rd_cyc),  64'd5);
        chk("ldw_lat",   64'(lat),     64'd6);
        chk("ldw_err",   64'(err_seen), 64'd0);
        chk("ldw_addr",  64'(addr_ok), 64'd1);
        chk("ldw_rdata", bus.RDATA,    64'h01234567_89ABCDEF);

        // ld at 0x48, READY never comes
        mem_word = 64'h5555AAAA_5555AAAA;
        run_req(1'b0, F3_D, 64'h48, 64'd0, -1);
        chk("ldto_rdcyc", 64'(rd_cyc),  64'd15);
        chk("ldto_lat",   64'(lat),     64'd16);
        chk("ldto_err",   64'(err_seen), 64'd1);
        chk("ldto_rdata", bus.RDATA,    64'h01234567_89ABCDEF);

        // sd at 0x50
        run_req(1'b1, F3_D, 64'h50, 64'hDEADBEEF_CAFEF00D, 0);
        chk("sd_lat",   64'(lat),    64'd2);
        chk("sd_rdcyc", 64'(rd_cyc), 64'd0);
        chk("sd_wdata", last_wdata,  64'hDEADBEEF_CAFEF00D);

        // RESET during the WR phase of sh
        mem_word = 64'hAAAAAAAA_AAAAAAAA;
        bus.REQ = 1'b1; bus.WE = 1'b1; bus.FUNCT3 = F3_H; bus.ADDR = 64'h02; bus.WDATA = 64'h1234;
        @(negedge clk);
        bus.REQ = 1'b0;
        chk("rwr_rd", 64'(bus.MEM_RD), 64'd1);
        bus.MEM_READY = 1'b1;
        @(negedge clk);
        chk("rwr_wr", 64'(bus.MEM_WR), 64'd1);
        bus.MEM_READY = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rwr_wr_drop", 64'(bus.MEM_WR), 64'd0);
        chk("rwr_busy",    64'(bus.BUSY),   64'd0);
        chk("rwr_done",    64'(bus.DONE),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.DONE) done_cnt++;
        end
        chk("rwr_nodone", 64'(done_cnt), 64'd0);

        // Following ld completes normally
        run_req(1'b0, F3_D, 64'h00, 64'd0, 0);
        chk("post_lat",   64'(lat),     64'd2);
        chk("post_err",   64'(err_seen), 64'd0);
        chk("post_rdata", bus.RDATA,    64'hAAAAAAAA_AAAAAAAA);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
